ifetch_req_ctrl: RTL and testbench

- Instruction-fetch request controller sitting directly upstream of the L1 instruction cache.
- Generates sequential fetch addresses and issues them over the icache request handshake, keeping at most one request outstanding.
- Buffers one response in an output register for the decoder, and handles redirect, halt and load-fault.

---
 rtl/ifetch_req_ctrl.sv | 141 ++++++++++++++
 tb/tb_ifetch_req_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_req_ctrl.sv
// Instruction-fetch request controller feeding the L1 icache: sequential fetch
// addresses, one request outstanding, single-entry instruction buffer toward decode.
module ifetch_req_ctrl #(
    parameter int              abus         = 48,
    parameter logic [abus-1:0] RESET_VECTOR = 48'h10000
) (
    input  logic            i_clk,
    input  logic            i_nrst,
    input  logic            i_halt,
    input  logic            i_redirect_valid,
    input  logic [abus-1:0] i_redirect_pc,
    output logic            o_mem_req_valid,
    output logic [abus-1:0] o_mem_req_addr,
    input  logic            i_mem_req_ready,
    input  logic            i_mem_data_valid,
    input  logic [abus-1:0] i_mem_data_addr,
    input  logic [31:0]     i_mem_data,
    input  logic            i_mem_load_fault,
    output logic            o_mem_resp_ready,
    output logic            o_instr_valid,
    output logic [abus-1:0] o_instr_pc,
    output logic [31:0]     o_instr,
    output logic            o_instr_load_fault,
    input  logic            i_decode_ready
);

    // state     | meaning
    // IDLE      | nothing pending; leaves when not halted and not fault-stopped
    // REQ_WAIT  | request presented to the icache, waiting for ready
    // WAIT_RESP | one request outstanding, waiting for its response
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ_WAIT  = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [abus-1:0] pc, pc_nxt;
    logic            discard, discard_nxt;
    logic            fault_stop, fault_stop_nxt;
    logic            instr_valid_nxt;
    logic [abus-1:0] instr_pc_nxt;
    logic [31:0]     instr_nxt;
    logic            instr_fault_nxt;

    logic            req_fire;
    logic            resp_accept;
    logic            resp_load;

    // Reset gates valid combinationally so nothing is offered before the first reset edge.
    assign o_mem_req_valid  = i_nrst && (state == REQ_WAIT) && !i_halt;
    assign o_mem_req_addr   = {pc[abus-1:2], 2'b00};
    assign o_mem_resp_ready = !o_instr_valid || i_decode_ready;

    assign req_fire    = o_mem_req_valid && i_mem_req_ready;
    assign resp_accept = (state == WAIT_RESP) && i_mem_data_valid && o_mem_resp_ready;
    assign resp_load   = resp_accept && !discard && !i_redirect_valid;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state              <= IDLE;
            pc                 <= RESET_VECTOR;
            discard            <= 1'b0;
            fault_stop         <= 1'b0;
            o_instr_valid      <= 1'b0;
            o_instr_pc         <= '0;
            o_instr            <= '0;
            o_instr_load_fault <= 1'b0;
        end else begin
            state              <= state_nxt;
            pc                 <= pc_nxt;
            discard            <= discard_nxt;
            fault_stop         <= fault_stop_nxt;
            o_instr_valid      <= instr_valid_nxt;
            o_instr_pc         <= instr_pc_nxt;
            o_instr            <= instr_nxt;
            o_instr_load_fault <= instr_fault_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        discard_nxt     = discard;
        fault_stop_nxt  = fault_stop;
        instr_valid_nxt = o_instr_valid;
        instr_pc_nxt    = o_instr_pc;
        instr_nxt       = o_instr;
        instr_fault_nxt = o_instr_load_fault;

        case (state)
            IDLE: begin
                if (!i_halt && !fault_stop)
                    state_nxt = REQ_WAIT;
            end
            REQ_WAIT: begin
                if (i_halt)
                    state_nxt = IDLE;
                else if (req_fire)
                    state_nxt = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (resp_accept)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (req_fire)
            pc_nxt = pc + abus'(4);

        if (resp_accept)
            discard_nxt = 1'b0;

        // A load in the same cycle as a consume wins: the buffer holds the new entry.
        if (resp_load) begin
            instr_valid_nxt = 1'b1;
            instr_pc_nxt    = i_mem_data_addr;
            instr_nxt       = i_mem_data;
            instr_fault_nxt = i_mem_load_fault;
            if (i_mem_load_fault)
                fault_stop_nxt = 1'b1;
        end else if (o_instr_valid && i_decode_ready) begin
            instr_valid_nxt = 1'b0;
        end

        // Redirect overrides everything; an in-flight or just-issued request becomes stale.
        if (i_redirect_valid) begin
            pc_nxt          = i_redirect_pc;
            instr_valid_nxt = 1'b0;
            fault_stop_nxt  = 1'b0;
            if (req_fire || ((state == WAIT_RESP) && !resp_accept))
                discard_nxt = 1'b1;
        end
    end

    no_stray_resp: assert property (@(posedge i_clk) disable iff (!i_nrst)
        !(i_mem_data_valid && (state != WAIT_RESP)))
        else $error("icache response with no request outstanding");

endmodule

// File: tb/tb_ifetch_req_ctrl.sv
// Self-checking bench for ifetch_req_ctrl: directed cycle tables for the corner
// cases, then randomized traffic against a transaction-level reference model.
module tb_ifetch_req_ctrl;

    localparam int AW = 48;
    localparam logic [AW-1:0] RV = 48'h10000;

    logic          i_clk = 1'b0;
    logic          i_nrst;
    logic          i_halt;
    logic          i_redirect_valid;
    logic [AW-1:0] i_redirect_pc;
    logic          o_mem_req_valid;
    logic [AW-1:0] o_mem_req_addr;
    logic          i_mem_req_ready;
    logic          i_mem_data_valid;
    logic [AW-1:0] i_mem_data_addr;
    logic [31:0]   i_mem_data;
    logic          i_mem_load_fault;
    logic          o_mem_resp_ready;
    logic          o_instr_valid;
    logic [AW-1:0] o_instr_pc;
    logic [31:0]   o_instr;
    logic          o_instr_load_fault;
    logic          i_decode_ready;

    always #5 i_clk = ~i_clk;

    ifetch_req_ctrl #(.abus(AW), .RESET_VECTOR(RV)) dut (
        .i_clk              (i_clk),
        .i_nrst             (i_nrst),
        .i_halt             (i_halt),
        .i_redirect_valid   (i_redirect_valid),
        .i_redirect_pc      (i_redirect_pc),
        .o_mem_req_valid    (o_mem_req_valid),
        .o_mem_req_addr     (o_mem_req_addr),
        .i_mem_req_ready    (i_mem_req_ready),
        .i_mem_data_valid   (i_mem_data_valid),
        .i_mem_data_addr    (i_mem_data_addr),
        .i_mem_data         (i_mem_data),
        .i_mem_load_fault   (i_mem_load_fault),
        .o_mem_resp_ready   (o_mem_resp_ready),
        .o_instr_valid      (o_instr_valid),
        .o_instr_pc         (o_instr_pc),
        .o_instr            (o_instr),
        .o_instr_load_fault (o_instr_load_fault),
        .i_decode_ready     (i_decode_ready)
    );

    typedef struct {
        logic          h, rr, dv;
        logic [AW-1:0] da;
        logic          fl, dr, rv;
        logic [AW-1:0] rp;
        logic          qv;
        logic [AW-1:0] qa;
        logic          rs, iv;
        logic [AW-1:0] ipc;
        logic          ifl;
    } vec_t;

    vec_t seq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [31:0] dfn(input logic [AW-1:0] a);
        return a[31:0] ^ 32'h1357_9bdf ^ {a[47:32], 16'h0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic h, rr, dv, input logic [AW-1:0] da, input logic fl, dr, rv,
                       input logic [AW-1:0] rp, input logic qv, input logic [AW-1:0] qa,
                       input logic rs, iv, input logic [AW-1:0] ipc, input logic ifl);
        vec_t v;
        v.h = h; v.rr = rr; v.dv = dv; v.da = da; v.fl = fl; v.dr = dr; v.rv = rv; v.rp = rp;
        v.qv = qv; v.qa = qa; v.rs = rs; v.iv = iv; v.ipc = ipc; v.ifl = ifl;
        seq.push_back(v);
    endtask

    // Fetch 0x10000, deliver it, then issue 0x10004 (ends in WaitResp).
    task automatic boot_rows();
        add(0,1,0,0,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 1,'h10000,1,0,0,0);
        add(0,1,1,'h10000,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 0,0,1,1,'h10000,0);
        add(0,1,0,0,0,1,0,0, 1,'h10004,1,0,0,0);
    endtask

    task automatic run_seq(input string tag);
        vec_t v;
        foreach (seq[i]) begin
            v = seq[i];
            @(negedge i_clk);
            i_nrst           = 1'b1;
            i_halt           = v.h;
            i_mem_req_ready  = v.rr;
            i_mem_data_valid = v.dv;
            i_mem_data_addr  = v.da;
            i_mem_data       = dfn(v.da);
            i_mem_load_fault = v.fl;
            i_decode_ready   = v.dr;
            i_redirect_valid = v.rv;
            i_redirect_pc    = v.rp;
            #1;
            chk($sformatf("%s[%0d].req_valid", tag, i), o_mem_req_valid, v.qv);
            if (v.qv)
                chk($sformatf("%s[%0d].req_addr", tag, i), o_mem_req_addr, v.qa);
            chk($sformatf("%s[%0d].resp_ready", tag, i), o_mem_resp_ready, v.rs);
            chk($sformatf("%s[%0d].instr_valid", tag, i), o_instr_valid, v.iv);
            if (v.iv) begin
                chk($sformatf("%s[%0d].instr_pc", tag, i), o_instr_pc, v.ipc);
                chk($sformatf("%s[%0d].instr", tag, i), o_instr, dfn(v.ipc));
                chk($sformatf("%s[%0d].instr_fault", tag, i), o_instr_load_fault, v.ifl);
            end
        end
        seq.delete();
    endtask

    task automatic do_reset(input logic stale, input logic [AW-1:0] sa);
        @(negedge i_clk);
        i_nrst           = 1'b0;
        i_halt           = 1'b0;
        i_mem_req_ready  = 1'b1;
        i_mem_data_valid = stale;
        i_mem_data_addr  = sa;
        i_mem_data       = dfn(sa);
        i_mem_load_fault = 1'b0;
        i_decode_ready   = 1'b1;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        #1;
        chk("rst.req_valid_before_edge", o_mem_req_valid, 0);
        @(negedge i_clk);
        #1;
        chk("rst.req_valid", o_mem_req_valid, 0);
        chk("rst.instr_valid", o_instr_valid, 0);
        chk("rst.instr_pc", o_instr_pc, 0);
        chk("rst.instr", o_instr, 0);
        chk("rst.instr_fault", o_instr_load_fault, 0);
    endtask

    // Reference model state for the random phase.
    logic [AW-1:0] m_pc, m_ipc, pend_addr;
    logic [31:0]   m_data;
    logic          m_valid, m_ifl, m_fault_stop;
    logic          pend, pend_fault, hs, acc, cons, fresh;
    int            pend_tag, epoch, lat, halt_cnt, idle_cnt, n_deliv;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        i_nrst = 1'b0; i_halt = 1'b0; i_redirect_valid = 1'b0; i_redirect_pc = '0;
        i_mem_req_ready = 1'b0; i_mem_data_valid = 1'b0; i_mem_data_addr = '0;
        i_mem_data = '0; i_mem_load_fault = 1'b0; i_decode_ready = 1'b1;

        // Sequential fetch, decoder stall with held response, halt in ReqWait.
        do_reset(0, 0);
        boot_rows();
        add(0,1,1,'h10004,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 0,0,1,1,'h10004,0);
        add(0,1,0,0,0,1,0,0, 1,'h10008,1,0,0,0);
        add(0,1,1,'h10008,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,0,0,0, 0,0,0,1,'h10008,0);
        add(0,1,0,0,0,0,0,0, 1,'h1000c,0,1,'h10008,0);
        add(0,1,1,'h1000c,0,0,0,0, 0,0,0,1,'h10008,0);
        add(0,1,1,'h1000c,0,0,0,0, 0,0,0,1,'h10008,0);
        add(0,1,1,'h1000c,0,1,0,0, 0,0,1,1,'h10008,0);
        add(0,1,0,0,0,1,0,0, 0,0,1,1,'h1000c,0);
        add(0,0,0,0,0,1,0,0, 1,'h10010,1,0,0,0);
        add(1,1,0,0,0,1,0,0, 0,0,1,0,0,0);
        add(1,1,0,0,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 0,0,1,0,0,0);
        add(0,0,0,0,0,1,0,0, 1,'h10010,1,0,0,0);
        run_seq("seq");

        // Redirect to 0x20002 while 0x10004 is outstanding.
        do_reset(0, 0);
        boot_rows();
        add(0,1,0,0,0,1,1,'h20002, 0,0,1,0,0,0);
        add(0,1,1,'h10004,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 1,'h20000,1,0,0,0);
        add(0,1,1,'h20000,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 0,0,1,1,'h20000,0);
        add(0,0,0,0,0,1,0,0, 1,'h20004,1,0,0,0);
        run_seq("redir_wait");

        // Redirect in the same cycle as the 0x10008 handshake.
        do_reset(0, 0);
        boot_rows();
        add(0,1,1,'h10004,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 0,0,1,1,'h10004,0);
        add(0,1,0,0,0,1,1,'h24000, 1,'h10008,1,0,0,0);
        add(0,1,1,'h10008,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 1,'h24000,1,0,0,0);
        add(0,1,1,'h24000,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 0,0,1,1,'h24000,0);
        run_seq("redir_hs");

        // Load fault at 0x10004 stops fetch until a redirect.
        do_reset(0, 0);
        boot_rows();
        add(0,1,1,'h10004,1,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 0,0,1,1,'h10004,1);
        add(0,1,0,0,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,1,'h30000, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 1,'h30000,1,0,0,0);
        add(0,1,1,'h30000,0,1,0,0, 0,0,1,0,0,0);
        add(0,1,0,0,0,1,0,0, 0,0,1,1,'h30000,0);
        run_seq("fault");

        // Reset while 0x10004 is outstanding, with its stale response arriving during reset.
        do_reset(0, 0);
        boot_rows();
        run_seq("pre_rst");
        do_reset(1, 'h10004);
        boot_rows();
        run_seq("post_rst");

        // Randomized traffic against the transaction-level model.
        do_reset(0, 0);
        m_pc = RV; m_valid = 0; m_ipc = '0; m_data = '0; m_ifl = 0; m_fault_stop = 0;
        pend = 0; pend_addr = '0; pend_fault = 0; pend_tag = 0; epoch = 0; lat = 0;
        halt_cnt = 0; idle_cnt = 0; n_deliv = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge i_clk);
            i_nrst = 1'b1;
            if (halt_cnt > 0) halt_cnt--;
            else if ($urandom_range(0, 39) == 0) halt_cnt = $urandom_range(1, 6);
            i_halt           = (halt_cnt > 0);
            i_mem_req_ready  = ($urandom_range(0, 3) != 0);
            i_decode_ready   = ($urandom_range(0, 3) != 0);
            i_redirect_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) i_redirect_pc = 48'hFFFF_FFFF_FFFE;
            else i_redirect_pc = {16'($urandom), 32'($urandom)};
            i_mem_data_valid = pend && (lat == 0);
            i_mem_data_addr  = pend_addr;
            i_mem_data       = dfn(pend_addr);
            i_mem_load_fault = pend_fault;
            #1;

            chk("rnd.instr_valid", o_instr_valid, m_valid);
            if (m_valid) begin
                chk("rnd.instr_pc", o_instr_pc, m_ipc);
                chk("rnd.instr", o_instr, m_data);
                chk("rnd.instr_fault", o_instr_load_fault, m_ifl);
            end
            chk("rnd.resp_ready", o_mem_resp_ready, !m_valid || i_decode_ready);
            chk("rnd.req_during_halt", i_halt && o_mem_req_valid, 0);
            chk("rnd.req_after_fault", m_fault_stop && o_mem_req_valid, 0);
            chk("rnd.req_while_outstanding", pend && o_mem_req_valid, 0);
            if (o_mem_req_valid)
                chk("rnd.req_addr", o_mem_req_addr, {m_pc[AW-1:2], 2'b00});
            if (!pend && !i_halt && !m_fault_stop && !o_mem_req_valid) idle_cnt++;
            else idle_cnt = 0;
            chk("rnd.fetch_stalled", idle_cnt > 3, 0);

            hs    = o_mem_req_valid && i_mem_req_ready;
            acc   = i_mem_data_valid && (!m_valid || i_decode_ready);
            cons  = m_valid && i_decode_ready;
            fresh = acc && (pend_tag == epoch) && !i_redirect_valid;
            if (cons) n_deliv++;
            if (pend && lat > 0) lat--;
            if (i_redirect_valid) begin
                m_valid = 0;
            end else if (fresh) begin
                m_valid = 1; m_ipc = pend_addr; m_data = dfn(pend_addr); m_ifl = pend_fault;
                if (pend_fault) m_fault_stop = 1;
            end else if (cons) begin
                m_valid = 0;
            end
            if (acc) pend = 0;
            if (hs) begin
                pend = 1; pend_addr = {m_pc[AW-1:2], 2'b00}; pend_tag = epoch;
                lat = $urandom_range(0, 2); pend_fault = ($urandom_range(0, 11) == 0);
                m_pc = m_pc + 48'd4;
            end
            if (i_redirect_valid) begin
                epoch++;
                m_pc = i_redirect_pc;
                m_fault_stop = 0;
            end
        end
        chk("rnd.progress", n_deliv > 50, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
